// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps a bank of LEDs through one of four patterns,
// advancing once per resynchronised rising edge of a slow tick.
module led_pattern_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic [1:0]       MODE,
    input  logic             HOLD,
    output logic [WIDTH-1:0] LED,
    output logic             STEP
);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'd0,
        M_ROTATE = 2'd1,
        M_COUNT  = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   adv;

    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] led_d;
    logic             step_d;
    logic [WIDTH-1:0] seed;

    // History follows the synchroniser even under HOLD, so no burst on release
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], TICK};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign adv = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LED    <= WIDTH'(1);
            STEP   <= 1'b0;
            mode_q <= M_BOUNCE;
            dir_q  <= DIR_UP;
        end else begin
            LED    <= led_d;
            STEP   <= step_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end

    always_comb begin
        seed = WIDTH'(1);
        unique case (mode_t'(MODE))
            M_BOUNCE: seed = WIDTH'(1);
            M_ROTATE: seed = WIDTH'(1);
            M_COUNT:  seed = '0;
            M_BLINK:  seed = '1;
        endcase
    end

    always_comb begin
        led_d  = LED;
        dir_d  = dir_q;
        mode_d = mode_q;
        step_d = 1'b0;
        if (adv && !HOLD) begin
            step_d = 1'b1;
            if (mode_t'(MODE) != mode_q) begin
                led_d  = seed;
                mode_d = mode_t'(MODE);
                dir_d  = DIR_UP;
            end else begin
                unique case (mode_q)
                    M_BOUNCE: begin
                        // Flip on landing at an end so ends are not repeated
                        if (dir_q == DIR_UP) begin
                            led_d = LED << 1;
                            if (led_d[WIDTH-1]) dir_d = DIR_DOWN;
                        end else begin
                            led_d = LED >> 1;
                            if (led_d[0]) dir_d = DIR_UP;
                        end
                    end
                    M_ROTATE: led_d = {LED[WIDTH-2:0], LED[WIDTH-1]};
                    M_COUNT:  led_d = LED + WIDTH'(1);
                    M_BLINK:  led_d = ~LED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: table vectors, hand-written corner sequences and
// random pulses checked against a step-index model of the four patterns.
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TICK;
    logic [1:0] MODE;
    logic       HOLD;
    logic [7:0] LED;
    logic       STEP;
    bit         clk_en = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: current pattern and number of advances since its seed
    int m_mode = 0;
    int m_k    = 0;

    typedef struct {
        logic [1:0] mode;
        logic       hold;
        logic [7:0] led;
        logic       step;
    } vec_t;

    vec_t tbl[$];

    led_pattern_sequencer #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (TICK),
        .MODE  (MODE),
        .HOLD  (HOLD),
        .LED   (LED),
        .STEP  (STEP)
    );

    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_led();
        int p;
        case (m_mode)
            0: begin
                p = m_k % 14;
                if (p > 7) p = 14 - p;
                return 8'(1 << p);
            end
            1: return 8'(1 << (m_k % 8));
            2: return 8'(m_k % 256);
            default: return (m_k % 2 == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic void model_adv(input logic [1:0] m, input logic h);
        if (h) return;
        if (int'(m) != m_mode) begin
            m_mode = int'(m);
            m_k = 0;
        end else begin
            m_k++;
        end
    endfunction

    function automatic void add(input logic [1:0] m, input logic h,
                                input logic [7:0] l, input logic s);
        vec_t v;
        v.mode = m;
        v.hold = h;
        v.led  = l;
        v.step = s;
        tbl.push_back(v);
    endfunction

    // One TICK pulse: high for hi edges, then low long enough to re-arm
    task automatic pulse(input logic [1:0] m, input logic h, input int hi,
                         output logic [7:0] led_o, output int steps,
                         output int first);
        @(negedge CLK);
        MODE = m;
        HOLD = h;
        TICK = 1'b1;
        steps = 0;
        first = 0;
        for (int e = 1; e <= hi + 4; e++) begin
            @(posedge CLK);
            #1;
            if (STEP) begin
                steps++;
                if (first == 0) first = e;
            end
            if (e == hi) TICK = 1'b0;
            if (e == 3) MODE = 2'($urandom);
        end
        led_o = LED;
        model_adv(m, h);
    endtask

    task automatic run_vec(input int i);
        logic [7:0] l;
        int s, f;
        pulse(tbl[i].mode, tbl[i].hold, 2, l, s, f);
        chk($sformatf("vec%0d led", i), 32'(l), 32'(tbl[i].led));
        chk($sformatf("vec%0d steps", i), s, tbl[i].step ? 1 : 0);
        if (tbl[i].step) chk($sformatf("vec%0d latency", i), f, 3);
    endtask

    initial begin
        logic [7:0] l;
        int s, f, seg1, seg2;
        logic [1:0] rm;
        logic rh;
        int changes;

        RESET = 1'b0;
        TICK  = 1'b0;
        MODE  = 2'd0;
        HOLD  = 1'b0;

        // Bounce run, then switch to count at 0x10
        add(0, 0, 8'h02, 1); add(0, 0, 8'h04, 1); add(0, 0, 8'h08, 1);
        add(0, 0, 8'h10, 1); add(0, 0, 8'h20, 1); add(0, 0, 8'h40, 1);
        add(0, 0, 8'h80, 1); add(0, 0, 8'h40, 1); add(0, 0, 8'h20, 1);
        add(0, 0, 8'h10, 1); add(0, 0, 8'h08, 1); add(0, 0, 8'h04, 1);
        add(0, 0, 8'h02, 1); add(0, 0, 8'h01, 1); add(0, 0, 8'h02, 1);
        add(0, 0, 8'h04, 1); add(0, 0, 8'h08, 1); add(0, 0, 8'h10, 1);
        add(2, 0, 8'h00, 1);
        seg1 = tbl.size();
        // Blink, then held pulses
        add(3, 0, 8'hFF, 1); add(3, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) add(3, 1, 8'h00, 0);
        seg2 = tbl.size();
        // Rotate through the wrap
        add(1, 0, 8'h01, 1); add(1, 0, 8'h02, 1); add(1, 0, 8'h04, 1);
        add(1, 0, 8'h08, 1); add(1, 0, 8'h10, 1); add(1, 0, 8'h20, 1);
        add(1, 0, 8'h40, 1); add(1, 0, 8'h80, 1); add(1, 0, 8'h01, 1);
        add(1, 0, 8'h02, 1);

        // Reset with the clock stopped
        #3 RESET = 1'b1;
        #1;
        chk("reset led", 32'(LED), 32'h01);
        chk("reset step", 32'(STEP), 32'h0);
        #4 RESET = 1'b0;
        clk_en = 1'b1;

        changes = 0;
        s = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (STEP) s++;
            if (LED !== 8'h01) changes++;
        end
        chk("idle steps", s, 0);
        chk("idle led changes", changes, 0);

        for (int i = 0; i < seg1; i++) run_vec(i);

        // Count 256 steps from seed, through 0xFF -> 0x00
        for (int i = 0; i < 256; i++) begin
            pulse(2, 0, 1 + (i % 3), l, s, f);
            chk($sformatf("count%0d led", i), 32'(l), 32'(model_led()));
            if (s != 1 || f != 3)
                chk($sformatf("count%0d step", i), s * 16 + f, 1 * 16 + 3);
        end
        chk("count wrap led", 32'(l), 32'h00);

        for (int i = seg1; i < seg2; i++) run_vec(i);

        // Release HOLD while TICK is still high: no late advance
        @(negedge CLK);
        MODE = 2'd3;
        HOLD = 1'b1;
        TICK = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        HOLD = 1'b0;
        s = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            if (STEP) s++;
        end
        chk("hold release steps", s, 0);
        chk("hold release led", 32'(LED), 32'h00);
        TICK = 1'b0;
        repeat (4) @(posedge CLK);
        pulse(3, 0, 2, l, s, f);
        chk("blink after hold led", 32'(l), 32'(model_led()));
        chk("blink after hold steps", s, 1);

        for (int i = seg2; i < tbl.size(); i++) run_vec(i);

        // Async reset between edges while an advance is pending
        @(negedge CLK);
        MODE = 2'd1;
        HOLD = 1'b0;
        TICK = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async reset led", 32'(LED), 32'h01);
        chk("async reset step", 32'(STEP), 32'h0);
        @(posedge CLK);
        #1;
        chk("reset wins led", 32'(LED), 32'h01);
        chk("reset wins step", 32'(STEP), 32'h0);
        TICK = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        m_mode = 0;
        m_k = 0;
        s = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            if (STEP) s++;
        end
        chk("post reset steps", s, 0);
        chk("post reset led", 32'(LED), 32'h01);
        pulse(1, 0, 2, l, s, f);
        chk("post reset seed led", 32'(l), 32'h01);
        chk("post reset seed steps", s, 1);

        // Random pulses against the model
        rm = 2'd1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(3) == 0) rm = 2'($urandom);
            rh = ($urandom_range(5) == 0);
            pulse(rm, rh, $urandom_range(1, 3), l, s, f);
            chk($sformatf("rand%0d led", i), 32'(l), 32'(model_led()));
            chk($sformatf("rand%0d steps", i), s, rh ? 0 : 1);
            if (!rh) chk($sformatf("rand%0d latency", i), f, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
